// File: rtl/tl_pkg.sv
// Shared encodings and timing defaults for the traffic-light phase timer.
// Imported by the phase sequencer and its lamp decoder.
package tl_pkg;

    typedef enum logic [1:0] {
        PH_ALLRED = 2'b00,
        PH_GREEN  = 2'b01,
        PH_YELLOW = 2'b10
    } phase_e;

    localparam logic [3:0] S1 = 4'b0001;
    localparam logic [3:0] S2 = 4'b0010;
    localparam logic [3:0] S3 = 4'b0100;
    localparam logic [3:0] S4 = 4'b1000;

    localparam int GREEN_MIN_DEF = 4;
    localparam int GREEN_MAX_DEF = 10;
    localparam int YELLOW_T_DEF  = 3;
    localparam int ALLRED_T_DEF  = 2;
    localparam int CNT_W_DEF     = 8;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v == S1) || (v == S2) || (v == S3) || (v == S4);
    endfunction

endpackage

// File: rtl/lamp_decode.sv
// Phase + one-hot side to per-side lamps; each side shows exactly one lamp.
// Purely combinational so display/debug logic can share it.
module lamp_decode
    import tl_pkg::*;
(
    input  logic [1:0] phase_i,
    input  logic [3:0] side_i,
    output logic [3:0] green_o,
    output logic [3:0] yellow_o,
    output logic [3:0] red_o
);

    always_comb begin
        green_o  = 4'b0000;
        yellow_o = 4'b0000;
        unique case (phase_i)
            PH_GREEN:  green_o  = side_i;
            PH_YELLOW: yellow_o = side_i;
            default: ;
        endcase
        red_o = ~(green_o | yellow_o);
    end

endmodule

// File: rtl/phase_timer.sv
// Times ALLRED -> GREEN -> YELLOW for the side chosen by the side FSM,
// drives the lamps and pulses Next once per green/yellow pass.
module phase_timer
    import tl_pkg::*;
#(
    parameter int GREEN_MIN = GREEN_MIN_DEF,
    parameter int GREEN_MAX = GREEN_MAX_DEF,
    parameter int YELLOW_T  = YELLOW_T_DEF,
    parameter int ALLRED_T  = ALLRED_T_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Side,
    input  logic             T1,
    input  logic             T2,
    input  logic             T3,
    input  logic             T4,
    output logic             Next,
    output logic [3:0]       Green,
    output logic [3:0]       Yellow,
    output logic [3:0]       Red,
    output logic [1:0]       Phase
);

    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] GMIN_LST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW_T - 1);

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             side_ok;
    logic             other_dmd;
    logic             next_c;

    assign side_ok   = is_onehot4(Side);
    // Demand on the active side itself never shortens green.
    assign other_dmd = |({T4, T3, T2, T1} & ~Side);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= PH_ALLRED;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q + 1'b1;
        next_c  = 1'b0;
        unique case (phase_q)
            PH_ALLRED: begin
                if (cnt_q >= AR_LAST) begin
                    cnt_d = AR_LAST;
                    if (side_ok) begin
                        phase_d = PH_GREEN;
                        cnt_d   = '0;
                    end
                end
            end
            PH_GREEN: begin
                if (!side_ok) begin
                    phase_d = PH_ALLRED;
                    cnt_d   = '0;
                end else if (cnt_q >= GMAX_LST ||
                             (cnt_q >= GMIN_LST && other_dmd)) begin
                    phase_d = PH_YELLOW;
                    cnt_d   = '0;
                end
            end
            PH_YELLOW: begin
                if (!side_ok) begin
                    phase_d = PH_ALLRED;
                    cnt_d   = '0;
                end else if (cnt_q >= Y_LAST) begin
                    next_c  = 1'b1;
                    phase_d = PH_ALLRED;
                    cnt_d   = '0;
                end
            end
            default: begin
                phase_d = PH_ALLRED;
                cnt_d   = '0;
            end
        endcase
    end

    assign Next  = next_c;
    assign Phase = phase_q;

    lamp_decode u_lamps (
        .phase_i  (phase_q),
        .side_i   (Side),
        .green_o  (Green),
        .yellow_o (Yellow),
        .red_o    (Red)
    );

endmodule
